// File: rtl/zmips_dbus_resp.sv
// zmips_dbus_resp: data-bus responder for the zmips core.
//
// Decodes each word address into a word-addressed data RAM (d_addr[31:ADDR_W] == 0) or a
// four-register MMIO page at MMIO_BASE. Unmapped reads return 0; unmapped writes are dropped.
//   +0 CON_DATA  write pushes a byte into the console FIFO, reads 0
//   +1 STAT      {TIRQ[9], OVF[8], COUNT[5:2], EMPTY[1], FULL[0]}; write 1 to 8/9 clears
//   +2 TIMER_CNT free-running counter, writable
//   +3 TIMER_CMP compare value; TIRQ sets when CNT == CMP and CMP != 0
//
// Optional feature macro: ZMIPS_DBUS_TIMER_EN (timer, TIRQ and timer_irq). When undefined,
// +2/+3 read 0 and ignore writes, STAT bit 9 reads 0 and timer_irq is tied low.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   d_addr, d_data_o       word address and write data from the core
//   d_wr, d_rd             write strobe (edge-sampled), read strobe (no side effects)
//   d_data_i               combinational read data to the core
//   con_data, con_valid    console FIFO head byte / non-empty
//   con_ready              downstream accepts the head byte
//   timer_irq              sticky timer compare flag
module zmips_dbus_resp #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_o,
  input  logic        d_wr,
  input  logic        d_rd,
  output logic [31:0] d_data_i,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        timer_irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  // Reads are side-effect free, so the strobe carries no information here.
  logic unused_rd;
  assign unused_rd = d_rd;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_off;
  logic        ram_sel;
  logic        mmio_sel;

  assign mmio_off = d_addr - MMIO_BASE;
  assign ram_sel  = (d_addr >> ADDR_W) == 32'd0;
  assign mmio_sel = !ram_sel && (mmio_off[31:2] == 30'd0);

  logic wr_ram, wr_con, wr_stat;
  assign wr_ram  = d_wr && !rst && ram_sel;
  assign wr_con  = d_wr && !rst && mmio_sel && (mmio_off[1:0] == 2'd0);
  assign wr_stat = d_wr && !rst && mmio_sel && (mmio_off[1:0] == 2'd1);

  // ---------------------------------------------------------------------------
  // Data RAM (not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem[d_addr[ADDR_W-1:0]] <= d_data_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  assign full  = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  // Both decisions use pre-edge state: a full FIFO rejects even with a concurrent pop.
  assign push  = wr_con && !full;
  assign pop   = !rst && !empty && con_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= d_data_o[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Overflow flag: set wins over a clear on the same edge
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_stat && d_data_o[8]) ovf_d = 1'b0;
    if (wr_con && full)         ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  logic        tirq;
  logic [31:0] cnt_rd, cmp_rd;

`ifdef ZMIPS_DBUS_TIMER_EN
  logic        wr_cnt, wr_cmp;
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        tirq_q, tirq_d;

  assign wr_cnt = d_wr && !rst && mmio_sel && (mmio_off[1:0] == 2'd2);
  assign wr_cmp = d_wr && !rst && mmio_sel && (mmio_off[1:0] == 2'd3);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (wr_cnt) cnt_d = d_data_o;
    cmp_d = cmp_q;
    if (wr_cmp) cmp_d = d_data_o;
    tirq_d = tirq_q;
    if (wr_stat && d_data_o[9])             tirq_d = 1'b0;
    if ((cnt_q == cmp_q) && (cmp_q != '0))  tirq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      cmp_q  <= '0;
      tirq_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      tirq_q <= tirq_d;
    end
  end

  assign tirq   = tirq_q;
  assign cnt_rd = cnt_q;
  assign cmp_rd = cmp_q;
`else
  assign tirq   = 1'b0;
  assign cnt_rd = '0;
  assign cmp_rd = '0;
`endif

  assign timer_irq = tirq;

  // ---------------------------------------------------------------------------
  // Read mux (combinational, shows pre-write state during a write cycle)
  // ---------------------------------------------------------------------------
  logic [4:0]  count_ext;
  logic [3:0]  count_field;
  logic [31:0] stat;

  assign count_ext   = 5'(count_q);
  assign count_field = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
  assign stat        = {22'd0, tirq, ovf_q, 2'b00, count_field, empty, full};

  always_comb begin
    d_data_i = '0;
    if (ram_sel) begin
      d_data_i = mem[d_addr[ADDR_W-1:0]];
    end else if (mmio_sel) begin
      unique case (mmio_off[1:0])
        2'd0:    d_data_i = '0;
        2'd1:    d_data_i = stat;
        2'd2:    d_data_i = cnt_rd;
        default: d_data_i = cmp_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_zmips_dbus_resp.sv
module tb_zmips_dbus_resp;

  localparam logic [31:0] Base = 32'hFFFF_FF00;
  localparam logic [31:0] ACon = Base;
  localparam logic [31:0] AStat = Base + 32'd1;
  localparam logic [31:0] ACnt = Base + 32'd2;
  localparam logic [31:0] ACmp = Base + 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr, d_data_o, d_data_i;
  logic        d_wr, d_rd;
  logic [7:0]  con_data;
  logic        con_valid, con_ready, timer_irq;

  int errors = 0;
  int checks = 0;

  zmips_dbus_resp dut (
    .clk       (clk),
    .rst       (rst),
    .d_addr    (d_addr),
    .d_data_o  (d_data_o),
    .d_wr      (d_wr),
    .d_rd      (d_rd),
    .d_data_i  (d_data_i),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    d_addr = addr; d_data_o = data; d_wr = 1'b1;
    tick();
    d_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (con_valid !== 1'b0) begin errors++;
      $display("FAIL reset_con_valid got %b want 0", con_valid); end
    checks++; if (con_data !== 8'h00) begin errors++;
      $display("FAIL reset_con_data got %h want 00", con_data); end
    checks++; if (timer_irq !== 1'b0) begin errors++;
      $display("FAIL reset_timer_irq got %b want 0", timer_irq); end
    d_addr = AStat; #1;
    checks++; if (d_data_i !== 32'h0000_0002) begin errors++;
      $display("FAIL reset_stat got %h want 00000002", d_data_i); end
    d_addr = ACnt; #1;
    checks++; if (d_data_i !== 32'h0) begin errors++;
      $display("FAIL reset_cnt got %h want 00000000", d_data_i); end
    d_addr = 32'h1234_5678; #1;
    checks++; if (d_data_i !== 32'h0) begin errors++;
      $display("FAIL unmapped_read got %h want 00000000", d_data_i); end
  endtask

  task automatic test_ram();
    bus_write(32'h0, 32'h1111_1111);
    bus_write(32'h5, 32'hDEAD_BEEF);
    d_addr = 32'h5; d_rd = 1'b1; #1;
    checks++; if (d_data_i !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL ram_read5 got %h want deadbeef", d_data_i); end
    bus_write(32'h0000_1000, 32'h2222_2222);
    d_addr = 32'h0000_1000; #1;
    checks++; if (d_data_i !== 32'h0) begin errors++;
      $display("FAIL ram_oob_read got %h want 00000000", d_data_i); end
    d_addr = 32'h0; #1;
    checks++; if (d_data_i !== 32'h1111_1111) begin errors++;
      $display("FAIL ram_word0_kept got %h want 11111111", d_data_i); end
    // Read and write together: old value visible until the edge.
    d_addr = 32'h5; d_data_o = 32'hCAFE_F00D; d_wr = 1'b1; #1;
    checks++; if (d_data_i !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL rw_prewrite got %h want deadbeef", d_data_i); end
    tick();
    d_wr = 1'b0;
    checks++; if (d_data_i !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL rw_postwrite got %h want cafef00d", d_data_i); end
    d_rd = 1'b0;
  endtask

  task automatic test_overflow_drain();
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(ACon, 32'h41 + i);
    d_addr = AStat; #1;
    checks++; if (d_data_i !== 32'h0000_0121) begin errors++;
      $display("FAIL ovf_stat got %h want 00000121", d_data_i); end
    bus_write(AStat, 32'h100);
    #1;
    checks++; if (d_data_i !== 32'h0000_0021) begin errors++;
      $display("FAIL ovf_clear got %h want 00000021", d_data_i); end
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (con_valid !== 1'b1 || con_data !== 8'(8'h41 + i)) begin errors++;
        $display("FAIL drain_byte%0d got v=%b d=%h want v=1 d=%h", i, con_valid, con_data,
                 8'(8'h41 + i)); end
      tick();
    end
    con_ready = 1'b0;
    checks++; if (con_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty got %b want 0", con_valid); end
    #1;
    checks++; if (d_data_i !== 32'h0000_0002) begin errors++;
      $display("FAIL drain_stat got %h want 00000002", d_data_i); end
  endtask

  task automatic test_push_pop_full();
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(ACon, 32'h30 + i);
    con_ready = 1'b1;
    bus_write(ACon, 32'h5A);
    con_ready = 1'b0;
    d_addr = AStat; #1;
    checks++; if (d_data_i !== 32'h0000_011C) begin errors++;
      $display("FAIL fullpop_stat got %h want 0000011c", d_data_i); end
    checks++; if (con_data !== 8'h31) begin errors++;
      $display("FAIL fullpop_head got %h want 31", con_data); end
    bus_write(AStat, 32'h100);
    #1;
    checks++; if (d_data_i !== 32'h0000_001C) begin errors++;
      $display("FAIL fullpop_clear got %h want 0000001c", d_data_i); end
    con_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checks++; if (con_data !== 8'(8'h30 + i)) begin errors++;
        $display("FAIL fullpop_byte%0d got %h want %h", i, con_data, 8'(8'h30 + i)); end
      tick();
    end
    con_ready = 1'b0;
    checks++; if (con_valid !== 1'b0) begin errors++;
      $display("FAIL fullpop_empty got %b want 0 (0x5A leaked)", con_valid); end
  endtask

  task automatic test_timer();
`ifdef ZMIPS_DBUS_TIMER_EN
    bus_write(ACmp, 32'd10);
    #1;
    checks++; if (d_data_i !== 32'd10) begin errors++;
      $display("FAIL cmp_readback got %h want 0000000a", d_data_i); end
    bus_write(ACnt, 32'd0);
    #1;
    checks++; if (d_data_i !== 32'd0) begin errors++;
      $display("FAIL cnt_load got %h want 00000000", d_data_i); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (timer_irq !== 1'b0 || d_data_i !== 32'(i)) begin errors++;
        $display("FAIL timer_pre%0d got irq=%b cnt=%h want irq=0 cnt=%h", i, timer_irq,
                 d_data_i, 32'(i)); end
    end
    tick();
    checks++; if (timer_irq !== 1'b1) begin errors++;
      $display("FAIL timer_fire got %b want 1", timer_irq); end
    tick(); tick(); tick();
    d_addr = AStat; #1;
    checks++; if (timer_irq !== 1'b1 || d_data_i !== 32'h0000_0202) begin errors++;
      $display("FAIL timer_sticky got irq=%b stat=%h want 1/00000202", timer_irq, d_data_i); end
    bus_write(AStat, 32'h200);
    checks++; if (timer_irq !== 1'b0) begin errors++;
      $display("FAIL timer_clear got %b want 0", timer_irq); end
`else
    bus_write(ACmp, 32'd10);
    bus_write(ACnt, 32'd77);
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_data_i !== 32'd0) begin errors++;
        $display("FAIL cnt_disabled%0d got %h want 00000000", i, d_data_i); end
      tick();
    end
    d_addr = ACmp; #1;
    checks++; if (d_data_i !== 32'd0 || timer_irq !== 1'b0) begin errors++;
      $display("FAIL cmp_disabled got %h irq=%b want 0/0", d_data_i, timer_irq); end
`endif
  endtask

  task automatic test_reset_mid_op();
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(ACon, 32'h61 + i);
    bus_write(32'h6, 32'h0000_1234);
    rst = 1'b1; d_addr = ACon; d_data_o = 32'h77; d_wr = 1'b1;
    tick();
    rst = 1'b0; d_wr = 1'b0;
    checks++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin errors++;
      $display("FAIL midrst_fifo got v=%b d=%h want 0/00", con_valid, con_data); end
    d_addr = AStat; #1;
    checks++; if (d_data_i !== 32'h0000_0002) begin errors++;
      $display("FAIL midrst_stat got %h want 00000002", d_data_i); end
    // RAM write under reset is ignored, contents survive reset.
    rst = 1'b1; d_addr = 32'h6; d_data_o = 32'h9999_9999; d_wr = 1'b1;
    tick();
    rst = 1'b0; d_wr = 1'b0; #1;
    checks++; if (d_data_i !== 32'h0000_1234) begin errors++;
      $display("FAIL midrst_ram got %h want 00001234", d_data_i); end
    d_addr = 32'h5; #1;
    checks++; if (d_data_i !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL midrst_ram_kept got %h want cafef00d", d_data_i); end
  endtask

  initial begin
    rst = 1'b1; d_addr = '0; d_data_o = '0; d_wr = 1'b0; d_rd = 1'b0; con_ready = 1'b0;
    #1;
    test_reset();
    test_ram();
    test_overflow_drain();
    test_push_pop_full();
    test_timer();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
